// File: rtl/ps_bigreg_bank.sv
// Bank of wide processor-written registers assembled from narrow MMIO word writes,
// committed per channel by a valid-index write. Optional readback ports: BIGREG_READBACK_EN.
module ps_bigreg_bank #(
  parameter int WORD_W   = 16,
  parameter int WORDS    = 16,
  parameter int CHANNELS = 3,
  parameter int ID_W     = 8,
  parameter int BASE_ID  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [ID_W-1:0]                    wr_id,
  input  logic [WORD_W-1:0]                  wr_data,
  output logic                               wr_resp_valid,
  output logic                               wr_hit,
  output logic [1:0]                         wr_resp,
  output logic [CHANNELS*WORDS*WORD_W-1:0]   out_data,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ready,
  output logic [CHANNELS*WORDS-1:0]          fresh_mask
`ifdef BIGREG_READBACK_EN
  ,
  input  logic                               rd_en,
  input  logic [ID_W-1:0]                    rd_id,
  output logic [WORD_W-1:0]                  rd_data,
  output logic                               rd_hit
`endif
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [WORD_W-1:0]         staging_r [CHANNELS*WORDS];
  logic [CHANNELS*WORDS-1:0] fresh_r;
  logic [CHANNELS-1:0]       out_valid_r;

  logic [31:0]               id_ext_s;
  logic [CHANNELS-1:0]       in_ch_s;
  logic [31:0]               off_s [CHANNELS];
  logic [CHANNELS*WORDS-1:0] word_hit_s;
  logic [CHANNELS-1:0]       valid_hit_s;
  logic [CHANNELS-1:0]       commit_s;

  assign id_ext_s   = {{(32-ID_W){1'b0}}, wr_id};
  assign fresh_mask = fresh_r;
  assign out_valid  = out_valid_r;

  // Per-channel window bounds are elaboration-time constants; decode is subtract-and-compare.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_dec
    localparam logic [31:0] LO = 32'(BASE_ID + c * (WORDS + 1));
    localparam logic [31:0] HI = LO + 32'(WORDS);
    assign in_ch_s[c]     = (id_ext_s >= LO) && (id_ext_s <= HI);
    assign off_s[c]       = id_ext_s - LO;
    assign valid_hit_s[c] = wr_en && in_ch_s[c] && (off_s[c] == 32'(WORDS));
    assign commit_s[c]    = valid_hit_s[c] && (&fresh_r[c*WORDS +: WORDS])
                            && (!out_valid_r[c] || out_ready[c]);
    for (genvar w = 0; w < WORDS; w++) begin : g_word
      assign word_hit_s[c*WORDS+w] = wr_en && in_ch_s[c] && (off_s[c] == 32'(w));
    end
  end

  // Staging words and their fresh bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS*WORDS; i++) begin
        staging_r[i] <= '0;
      end
      fresh_r <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int w = 0; w < WORDS; w++) begin
          if (word_hit_s[c*WORDS+w]) begin
            staging_r[c*WORDS+w] <= wr_data;
            fresh_r[c*WORDS+w]   <= 1'b1;
          end else if (commit_s[c]) begin
            fresh_r[c*WORDS+w]   <= 1'b0;
          end
        end
      end
    end
  end

  // Committed values and the per-channel valid/ready handshake; a commit wins over a consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_valid_r <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (commit_s[c]) begin
          for (int w = 0; w < WORDS; w++) begin
            out_data[(c*WORDS+w)*WORD_W +: WORD_W] <= staging_r[c*WORDS+w];
          end
          out_valid_r[c] <= 1'b1;
        end else if (out_valid_r[c] && out_ready[c]) begin
          out_valid_r[c] <= 1'b0;
        end
      end
    end
  end

  // Write response, one cycle after the strobe and idle otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_resp_valid <= 1'b0;
      wr_hit        <= 1'b0;
      wr_resp       <= RESP_OKAY;
    end else begin
      wr_resp_valid <= wr_en;
      wr_hit        <= wr_en && (|in_ch_s);
      wr_resp       <= (|(valid_hit_s & ~commit_s)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

`ifdef BIGREG_READBACK_EN
  function automatic logic [6:0] popcount(input logic [WORDS-1:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < WORDS; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  logic [31:0]               rd_ext_s;
  logic [CHANNELS-1:0]       rd_in_ch_s;
  logic [31:0]               rd_off_s [CHANNELS];
  logic [CHANNELS*WORDS-1:0] rd_word_hit_s;
  logic [CHANNELS-1:0]       rd_valid_hit_s;
  logic [WORD_W-1:0]         rd_sel_s;

  assign rd_ext_s = {{(32-ID_W){1'b0}}, rd_id};

  // Read-side decode mirrors the write windows.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_rdec
    localparam logic [31:0] LO = 32'(BASE_ID + c * (WORDS + 1));
    localparam logic [31:0] HI = LO + 32'(WORDS);
    assign rd_in_ch_s[c]     = (rd_ext_s >= LO) && (rd_ext_s <= HI);
    assign rd_off_s[c]       = rd_ext_s - LO;
    assign rd_valid_hit_s[c] = rd_in_ch_s[c] && (rd_off_s[c] == 32'(WORDS));
    for (genvar w = 0; w < WORDS; w++) begin : g_rword
      assign rd_word_hit_s[c*WORDS+w] = rd_in_ch_s[c] && (rd_off_s[c] == 32'(w));
    end
  end

  // Read mux: staging word, or status word {out_valid, fresh popcount}.
  always_comb begin
    rd_sel_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int w = 0; w < WORDS; w++) begin
        if (rd_word_hit_s[c*WORDS+w]) begin
          rd_sel_s = staging_r[c*WORDS+w];
        end else begin
          rd_sel_s = rd_sel_s;
        end
      end
      if (rd_valid_hit_s[c]) begin
        rd_sel_s               = '0;
        rd_sel_s[WORD_W-2:0]   = (WORD_W-1)'(popcount(fresh_r[c*WORDS +: WORDS]));
        rd_sel_s[WORD_W-1]     = out_valid_r[c];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Registered read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else if (rd_en && (|rd_in_ch_s)) begin
      rd_data <= rd_sel_s;
      rd_hit  <= 1'b1;
    end else begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ps_bigreg_bank.sv
// Directed self-checking bench for ps_bigreg_bank with CHANNELS=3, WORDS=2, BASE_ID=1.
// Channel windows: ch0 ids 1,2 valid 3; ch1 ids 4,5 valid 6; ch2 ids 7,8 valid 9.
module tb_ps_bigreg_bank;
  localparam int WORD_W = 16, WORDS = 2, CHANNELS = 3, ID_W = 8, BASE_ID = 1;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             wr_en = 1'b0;
  logic [ID_W-1:0]                  wr_id = '0;
  logic [WORD_W-1:0]                wr_data = '0;
  logic                             wr_resp_valid;
  logic                             wr_hit;
  logic [1:0]                       wr_resp;
  logic [CHANNELS*WORDS*WORD_W-1:0] out_data;
  logic [CHANNELS-1:0]              out_valid;
  logic [CHANNELS-1:0]              out_ready = '0;
  logic [CHANNELS*WORDS-1:0]        fresh_mask;
`ifdef BIGREG_READBACK_EN
  logic                             rd_en = 1'b0;
  logic [ID_W-1:0]                  rd_id = '0;
  logic [WORD_W-1:0]                rd_data;
  logic                             rd_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ps_bigreg_bank #(.WORD_W(WORD_W), .WORDS(WORDS), .CHANNELS(CHANNELS),
                   .ID_W(ID_W), .BASE_ID(BASE_ID)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .wr_resp_valid(wr_resp_valid), .wr_hit(wr_hit), .wr_resp(wr_resp),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fresh_mask(fresh_mask)
`ifdef BIGREG_READBACK_EN
    , .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data), .rd_hit(rd_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one write for one cycle; returns #1 after the sampling edge.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [WORD_W-1:0] data);
    wr_en = 1'b1; wr_id = id; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic hit, input logic [1:0] resp);
    chk({tag, "_rv"}, 64'(wr_resp_valid), 64'd1);
    chk({tag, "_hit"}, 64'(wr_hit), 64'(hit));
    chk({tag, "_resp"}, 64'(wr_resp), 64'(resp));
  endtask

`ifdef BIGREG_READBACK_EN
  task automatic do_read(input logic [ID_W-1:0] id);
    rd_en = 1'b1; rd_id = id;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fresh", 64'(fresh_mask), 64'd0);
    chk("rst_out_data", 64'(out_data[63:0]), 64'd0);
    chk("rst_rv", 64'(wr_resp_valid), 64'd0);
    chk("rst_hit", 64'(wr_hit), 64'd0);
    chk("rst_resp", 64'(wr_resp), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: assemble and commit channel 0
    do_write(8'd1, 16'hAAAA);
    chk_resp("t1_w1", 1'b1, 2'b00);
    chk("t1_fresh1", 64'(fresh_mask), 64'h01);
    do_write(8'd2, 16'h5555);
    chk_resp("t1_w2", 1'b1, 2'b00);
    chk("t1_fresh2", 64'(fresh_mask), 64'h03);
    do_write(8'd3, 16'h0000);
    chk_resp("t1_v", 1'b1, 2'b00);
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_data0", 64'(out_data[31:0]), 64'h5555AAAA);
    chk("t1_fresh0", 64'(fresh_mask), 64'h00);
    @(posedge clk); #1;
    chk("t1_rv_idle", 64'(wr_resp_valid), 64'd0);
    chk("t1_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 3'b001;
    @(posedge clk); #1;
    out_ready = 3'b000;
    chk("t1_consumed", 64'(out_valid), 64'h0);
    chk("t1_data_hold", 64'(out_data[31:0]), 64'h5555AAAA);

    // Test 2: incomplete commit on channel 1
    do_write(8'd4, 16'h1111);
    chk("t2_fresh", 64'(fresh_mask), 64'h04);
    do_write(8'd6, 16'hFFFF);
    chk_resp("t2_v", 1'b1, 2'b10);
    chk("t2_out_valid", 64'(out_valid), 64'h0);
    chk("t2_fresh_kept", 64'(fresh_mask), 64'h04);
    chk("t2_data1", 64'(out_data[63:32]), 64'h0);

    // Test 3: busy channel 2, then commit coinciding with consume
    do_write(8'd7, 16'h7777);
    do_write(8'd8, 16'h8888);
    do_write(8'd9, 16'h0000);
    chk_resp("t3_v1", 1'b1, 2'b00);
    chk("t3_out_valid1", 64'(out_valid), 64'h4);
    chk("t3_data2a", 64'(out_data[95:64]), 64'h88887777);
    do_write(8'd7, 16'h1111);
    do_write(8'd8, 16'h2222);
    chk("t3_fresh_restage", 64'(fresh_mask), 64'h34);
    chk("t3_data_stable", 64'(out_data[95:64]), 64'h88887777);
    do_write(8'd9, 16'h0000);
    chk_resp("t3_v2_busy", 1'b1, 2'b10);
    chk("t3_data_kept", 64'(out_data[95:64]), 64'h88887777);
    chk("t3_fresh_kept", 64'(fresh_mask), 64'h34);
    out_ready = 3'b100;
    do_write(8'd9, 16'h0000);
    out_ready = 3'b000;
    chk_resp("t3_v3", 1'b1, 2'b00);
    chk("t3_out_valid3", 64'(out_valid), 64'h4);
    chk("t3_data2b", 64'(out_data[95:64]), 64'h22221111);
    chk("t3_fresh_after", 64'(fresh_mask), 64'h04);
    @(posedge clk); #1;
    chk("t3_valid_held", 64'(out_valid), 64'h4);

    // Test 4: indices outside the bank
    do_write(8'd0, 16'hFFFF);
    chk_resp("t4_id0", 1'b0, 2'b00);
    do_write(8'd10, 16'hFFFF);
    chk_resp("t4_id10", 1'b0, 2'b00);
    chk("t4_fresh", 64'(fresh_mask), 64'h04);
    chk("t4_out_valid", 64'(out_valid), 64'h4);
    chk("t4_data", 64'(out_data[63:0]), 64'h000000005555AAAA);

    // Test 5: asynchronous reset mid-assembly
    do_write(8'd1, 16'h1234);
    do_write(8'd2, 16'h5678);
    chk("t5_fresh_pre", 64'(fresh_mask), 64'h07);
    #2 rst = 1'b1;
    #1;
    chk("t5_fresh_async", 64'(fresh_mask), 64'h00);
    chk("t5_valid_async", 64'(out_valid), 64'h0);
    chk("t5_data_async", 64'(out_data[95:64]), 64'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_write(8'd3, 16'h0000);
    chk_resp("t5_v", 1'b1, 2'b10);
    chk("t5_out_valid", 64'(out_valid), 64'h0);

`ifdef BIGREG_READBACK_EN
    // Test 6: readback of a staging word and a channel status word
    do_write(8'd4, 16'h1234);
    do_read(8'd4);
    chk("t6_rd_word", 64'(rd_data), 64'h1234);
    chk("t6_hit_word", 64'(rd_hit), 64'd1);
    do_read(8'd6);
    chk("t6_rd_status", 64'(rd_data), 64'h0001);
    chk("t6_hit_status", 64'(rd_hit), 64'd1);
    do_read(8'd0);
    chk("t6_rd_miss", 64'(rd_data), 64'h0);
    chk("t6_hit_miss", 64'(rd_hit), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps_bigreg_bank.md
# ps_bigreg_bank

Parametrised bank of processor-written wide registers ("big registers") built from narrow MMIO word writes. Each channel collects WORDS data words into a staging buffer, tracks which words are fresh, and commits the assembled value to the RTL side when the processor writes that channel's valid index. The committed value is delivered over a valid/ready handshake. The block sits between the AXI-lite memory-map write decode and the RTL consumers of seed, channel-mux and sample-discriminator style registers. It generalises the existing fixed base/valid index pairs to any number of channels and words.

## Interface
- WORD_W, 16, width of one MMIO data word.
- WORDS, 16, data words per big register (1..64).
- CHANNELS, 3, number of independent big registers.
- ID_W, 8, width of the memory-map index.
- BASE_ID, 1, index of channel 0 word 0.

Channel c occupies indices BASE_ID + c*(WORDS+1) + w for w in 0..WORDS-1. Its valid index is BASE_ID + c*(WORDS+1) + WORDS.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous and active-high.
- wr_en  in  1  single-cycle write strobe from memory-map decode.
- wr_id  in  ID_W  write index.
- wr_data  in  WORD_W  write data.
- wr_resp_valid  out  1  response strobe, one cycle after wr_en.
- wr_hit  out  1  with the response: index belonged to this bank.
- wr_resp  out  2  with the response: OKAY 2'b00 or SLVERR 2'b10.
- out_data  out  CHANNELS*WORDS*WORD_W  committed registers. Channel c word w is at bits [(c*WORDS+w)*WORD_W +: WORD_W].
- out_valid  out  CHANNELS  per-channel committed-and-unconsumed flag.
- out_ready  in  CHANNELS  per-channel consumer accept.
- fresh_mask  out  CHANNELS*WORDS  per-word fresh bits, for status/debug.

## Operation
- Word write (index maps to channel c, word w):
  - Store wr_data in staging[c][w] and set fresh[c][w]. Rewriting an already-fresh word overwrites it.
  - Response is wr_hit=1, wr_resp=OKAY.
- Valid write to channel c (wr_data ignored):
  - Commit: all WORDS fresh bits set AND (out_valid[c]==0 OR out_ready[c]==1 in the same cycle). Copy staging[c] to out_data[c], set out_valid[c], clear all fresh[c]. Response is OKAY.
  - Incomplete (some fresh bit clear): no commit. Staging and fresh bits are kept. Response is SLVERR.
  - Busy (out_valid[c]==1 and out_ready[c]==0): no commit. Staging and fresh bits are kept. Response is SLVERR.
- Index outside the bank: no state change. Response is wr_hit=0, wr_resp=OKAY. The upstream decoder handles DECERR.
- Handshake, per channel:
  - out_valid[c] && out_ready[c] consumes the value and clears out_valid[c] next cycle, unless a commit on the same channel occurs in that cycle, in which case out_valid[c] stays 1 and carries the new data.
  - out_data[c] is stable while out_valid[c]=1. It holds its last committed value after consumption.
- Channels are fully independent. Only one write per cycle is possible, so there are no write-write collisions.
- Index decode uses subtraction and comparison against per-channel bounds. The bounds are computed at elaboration; no runtime division.

## Timing
- Reset values: staging 0, fresh_mask 0, out_data 0, out_valid 0, wr_resp_valid 0, wr_hit 0, wr_resp 2'b00.
- Reset in the middle of assembly discards all partial staging.
- Staging and fresh bits update on the clock edge that samples wr_en.
- wr_resp_valid, wr_hit and wr_resp are registered: they are valid exactly 1 cycle after wr_en and are 0 otherwise.
- Commit latency: out_valid[c] and out_data[c] update on the edge sampling the valid write, i.e. visible 1 cycle after wr_en, the same cycle as the response.
- Consume: out_valid[c] falls 1 cycle after the cycle where valid&&ready.
- A word write to channel c in the same cycle out_valid[c] is high is legal. It only affects staging.

## Configuration
- BIGREG_READBACK_EN defined: adds read ports rd_en (in, 1), rd_id (in, ID_W), rd_data (out, WORD_W) and rd_hit (out, 1), all registered with 1-cycle latency.
  - Word index: rd_data returns staging[c][w].
  - Valid index: rd_data returns the popcount of fresh[c] zero-extended, with bit WORD_W-1 = out_valid[c].
  - Miss: rd_hit=0, rd_data=0.
  - Reads never change state.
- BIGREG_READBACK_EN undefined: the ports are absent and no read mux logic is generated.

## Test plan
1. Reset with CHANNELS=3, WORDS=2, BASE_ID=1. Write 0xAAAA to id 1, 0x5555 to id 2, then id 3. Required: OKAY x3; out_valid=3'b001; channel 0 out_data={0x5555,0xAAAA}; fresh_mask=0.
2. Write only id 4, then valid id 6. Required: SLVERR; out_valid[1]=0; fresh_mask bit for channel 1 word 0 still set.
3. With out_ready=0, commit channel 2 (ids 7, 8, 9), then write ids 7, 8 again and id 9. Required: second commit SLVERR; out_data keeps the first value. Then assert out_ready[2] in the same cycle as a third write to id 9: OKAY; out_valid[2] stays 1; new data is shown.
4. Write to id 0 and id 10. Required: wr_hit=0, wr_resp=OKAY; no state change.
5. Write ids 1 and 2, then assert rst asynchronously between clock edges. Required: fresh_mask and out_valid are 0 immediately. A subsequent write to id 3 alone gives SLVERR.
6. With BIGREG_READBACK_EN: after writing id 4=0x1234, read id 4 then id 6. Required: rd_data=0x1234, then 0x0001; rd_hit=1 both times.
